fp_mul_param: RTL and testbench

Parametrised IEEE-754-style floating-point multiplier controller: accepts two packed operands via a valid/ready handshake, classifies specials, runs a sequential mantissa multiply, normalises, rounds under a selectable mode, and returns a packed result with a 3-bit exception code. It is the configurable-width successor of the single-precision multiplier controller in the FPU datapath. It adds full special-value handling, four rounding modes and output backpressure.

---
 rtl/fp_mul_pkg.sv | 32 +++
 rtl/mant_mul_seq.sv | 58 +++++
 rtl/fp_mul_param.sv | 223 ++++++++++++++++++++++
 tb/tb_fp_mul_param.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the parametrised floating-point multiplier.
package fp_mul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_MULT   = 3'd2,
        ST_NORM   = 3'd3,
        ST_ROUND  = 3'd4,
        ST_OUT    = 3'd5
    } fp_mul_state_t;

    localparam logic [2:0] EXC_NONE = 3'b000;
    localparam logic [2:0] EXC_UNF  = 3'b001;
    localparam logic [2:0] EXC_OVF  = 3'b010;
    localparam logic [2:0] EXC_INV  = 3'b011;
    localparam logic [2:0] EXC_INX  = 3'b101;

    localparam logic [1:0] RND_RNE = 2'b00;
    localparam logic [1:0] RND_RTZ = 2'b01;
    localparam logic [1:0] RND_RUP = 2'b10;
    localparam logic [1:0] RND_RDN = 2'b11;

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/mant_mul_seq.sv
// Radix-2 shift-add unsigned multiplier; the first partial product is folded
// into the start cycle so done pulses exactly N cycles after start.
module mant_mul_seq #(
    parameter int N = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int CW = $clog2(N);

    logic [N-1:0]   mcand;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           running;
    logic           done_q;

    // {hi, lo}: add multiplicand into hi when lo[0] is set, then shift right by one
    function automatic logic [2*N-1:0] shift_add(input logic [2*N-1:0] p, input logic [N-1:0] m);
        logic [N:0] s;
        s = {1'b0, p[2*N-1:N]} + (p[0] ? {1'b0, m} : {(N+1){1'b0}});
        return {s, p[N-1:1]};
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                acc     <= shift_add({{N{1'b0}}, b}, a);
                mcand   <= a;
                cnt     <= CW'(N - 1);
                running <= 1'b1;
            end else if (running) begin
                acc <= shift_add(acc, mcand);
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    running <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign done    = done_q;
    assign product = acc;

endmodule

// File: rtl/fp_mul_param.sv
// Parametrised floating-point multiplier controller with handshake in/out.
// state  | meaning
// IDLE   | ready for operands
// UNPACK | classify operands, resolve specials or start multiply
// MULT   | wait for mantissa product
// NORM   | normalise product, extract guard/sticky
// ROUND  | round, range-check, build result
// OUT    | hold result until consumer accepts
module fp_mul_param
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [EXP_W+MAN_W:0]   Datain1,
    input  logic [EXP_W+MAN_W:0]   Datain2,
    input  logic [1:0]             Rnd,
    input  logic                   Data_valid,
    output logic                   Data_ready,
    output logic [EXP_W+MAN_W:0]   Dataout,
    output logic                   Dataout_valid,
    input  logic                   Dataout_ready,
    output logic [2:0]             Exc,
    output logic                   Busy
);

    localparam int W  = fp_width(EXP_W, MAN_W);
    localparam int N  = MAN_W + 1;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_S   = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;

    fp_mul_state_t state;

    logic [W-1:0]          op1, op2;
    logic [1:0]            rnd_q;
    logic                  sign_q;
    logic signed [EW-1:0]  exp_q;
    logic [2*N-1:0]        prod_q;
    logic [MAN_W-1:0]      frac_q;
    logic                  g_q, s_q;
    logic [W-1:0]          dout_q;
    logic                  dout_valid_q;
    logic [2:0]            exc_q;

    logic                  mul_start, mul_done;
    logic [2*N-1:0]        mul_prod;

    logic [EXP_W-1:0]      e1, e2;
    logic [MAN_W-1:0]      f1, f2;
    logic                  nan1, nan2, inf1, inf2, zero1, zero2, special, sign_u;
    logic signed [EW-1:0]  exp_sum;
    logic [W-1:0]          spc_res;
    logic [2:0]            spc_exc;

    assign e1 = op1[W-2 -: EXP_W];
    assign e2 = op2[W-2 -: EXP_W];
    assign f1 = op1[MAN_W-1:0];
    assign f2 = op2[MAN_W-1:0];

    // Denormals (exp=0) are folded into zero
    assign nan1    = (e1 == EXP_ONES) && (f1 != '0);
    assign nan2    = (e2 == EXP_ONES) && (f2 != '0);
    assign inf1    = (e1 == EXP_ONES) && (f1 == '0);
    assign inf2    = (e2 == EXP_ONES) && (f2 == '0);
    assign zero1   = (e1 == '0);
    assign zero2   = (e2 == '0);
    assign special = nan1 | nan2 | inf1 | inf2 | zero1 | zero2;
    assign sign_u  = op1[W-1] ^ op2[W-1];
    assign exp_sum = $signed({2'b00, e1}) + $signed({2'b00, e2}) - BIAS_S;

    always_comb begin
        spc_res = '0;
        spc_exc = EXC_NONE;
        if (nan1 || nan2 || (inf1 && zero2) || (zero1 && inf2)) begin
            spc_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            spc_exc = EXC_INV;
        end else if (inf1 || inf2) begin
            spc_res = {sign_u, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            spc_res = {sign_u, {(W-1){1'b0}}};
        end
    end

    assign mul_start = (state == ST_UNPACK) && !special;

    mant_mul_seq #(.N(N)) u_mant_mul (
        .CLK     (CLK),
        .RST     (RST),
        .start   (mul_start),
        .a       ({1'b1, f1}),
        .b       ({1'b1, f2}),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Product of two [1,2) mantissas lies in [1,4); align the leading one to the top
    logic [2*N-2:0]   norm_p;
    logic [MAN_W-1:0] frac_n;
    logic             g_n, s_n;

    assign norm_p = prod_q[2*N-1] ? prod_q[2*N-2:0] : {prod_q[2*N-3:0], 1'b0};
    assign frac_n = norm_p[2*N-2 -: MAN_W];
    assign g_n    = norm_p[2*N-2-MAN_W];
    assign s_n    = |norm_p[2*N-3-MAN_W:0];

    logic                 round_up, ovf_inf;
    logic [MAN_W:0]       frac_sum;
    logic signed [EW-1:0] exp_r;
    logic [W-1:0]         rnd_res;
    logic [2:0]           rnd_exc;

    always_comb begin
        round_up = 1'b0;
        case (rnd_q)
            RND_RNE: round_up = g_q & (frac_q[0] | s_q);
            RND_RTZ: round_up = 1'b0;
            RND_RUP: round_up = !sign_q & (g_q | s_q);
            default: round_up = sign_q & (g_q | s_q);
        endcase
    end

    assign frac_sum = {1'b0, frac_q} + {{MAN_W{1'b0}}, round_up};
    assign exp_r    = frac_sum[MAN_W] ? exp_q + EW'(1) : exp_q;
    assign ovf_inf  = (rnd_q == RND_RNE) || ((rnd_q == RND_RUP) && !sign_q) ||
                      ((rnd_q == RND_RDN) && sign_q);

    always_comb begin
        rnd_res = '0;
        rnd_exc = EXC_NONE;
        if (exp_r >= EXP_MAX) begin
            rnd_exc = EXC_OVF;
            rnd_res = ovf_inf ? {sign_q, EXP_ONES, {MAN_W{1'b0}}}
                              : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else if (exp_r <= EXP_ZERO) begin
            rnd_exc = EXC_UNF;
            rnd_res = {sign_q, {(W-1){1'b0}}};
        end else begin
            rnd_exc = (g_q | s_q) ? EXC_INX : EXC_NONE;
            rnd_res = {sign_q, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            op1          <= '0;
            op2          <= '0;
            rnd_q        <= RND_RNE;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            prod_q       <= '0;
            frac_q       <= '0;
            g_q          <= 1'b0;
            s_q          <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            exc_q        <= EXC_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Data_valid && Data_ready) begin
                        op1   <= Datain1;
                        op2   <= Datain2;
                        rnd_q <= Rnd;
                        state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    sign_q <= sign_u;
                    if (special) begin
                        dout_q       <= spc_res;
                        exc_q        <= spc_exc;
                        dout_valid_q <= 1'b1;
                        state        <= ST_OUT;
                    end else begin
                        exp_q <= exp_sum;
                        state <= ST_MULT;
                    end
                end
                ST_MULT: begin
                    if (mul_done) begin
                        prod_q <= mul_prod;
                        state  <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    frac_q <= frac_n;
                    g_q    <= g_n;
                    s_q    <= s_n;
                    if (prod_q[2*N-1])
                        exp_q <= exp_q + EW'(1);
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    dout_q       <= rnd_res;
                    exc_q        <= rnd_exc;
                    dout_valid_q <= 1'b1;
                    state        <= ST_OUT;
                end
                ST_OUT: begin
                    if (Dataout_ready) begin
                        dout_valid_q <= 1'b0;
                        exc_q        <= EXC_NONE;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Data_ready    = (state == ST_IDLE) && !RST;
    assign Busy          = (state != ST_IDLE);
    assign Dataout       = dout_q;
    assign Dataout_valid = dout_valid_q;
    assign Exc           = exc_q;

endmodule

// File: tb/tb_fp_mul_param.sv
// Bench for fp_mul_param: single- and half-precision instances checked against
// an exact-integer reference model, plus directed latency/backpressure/reset cases.
module tb_fp_mul_param;

    logic CLK, RST;

    logic [31:0] sp_d1, sp_d2, sp_dout;
    logic [1:0]  sp_rnd;
    logic        sp_dv, sp_dr, sp_ov, sp_or, sp_busy;
    logic [2:0]  sp_exc;

    logic [15:0] hp_d1, hp_d2, hp_dout;
    logic [1:0]  hp_rnd;
    logic        hp_dv, hp_dr, hp_ov, hp_or, hp_busy;
    logic [2:0]  hp_exc;

    int n_chk = 0;
    int n_err = 0;

    fp_mul_param #(.EXP_W(8), .MAN_W(23)) u_sp (
        .CLK(CLK), .RST(RST), .Datain1(sp_d1), .Datain2(sp_d2), .Rnd(sp_rnd),
        .Data_valid(sp_dv), .Data_ready(sp_dr), .Dataout(sp_dout), .Dataout_valid(sp_ov),
        .Dataout_ready(sp_or), .Exc(sp_exc), .Busy(sp_busy)
    );

    fp_mul_param #(.EXP_W(5), .MAN_W(10)) u_hp (
        .CLK(CLK), .RST(RST), .Datain1(hp_d1), .Datain2(hp_d2), .Rnd(hp_rnd),
        .Data_valid(hp_dv), .Data_ready(hp_dr), .Dataout(hp_dout), .Dataout_valid(hp_ov),
        .Dataout_ready(hp_or), .Exc(hp_exc), .Busy(hp_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic        out_valid(input bit hp); return hp ? hp_ov : sp_ov; endfunction
    function automatic logic        in_ready(input bit hp);  return hp ? hp_dr : sp_dr; endfunction
    function automatic logic        busy(input bit hp);      return hp ? hp_busy : sp_busy; endfunction
    function automatic logic [2:0]  out_exc(input bit hp);   return hp ? hp_exc : sp_exc; endfunction
    function automatic logic [31:0] out_data(input bit hp);  return hp ? {16'h0, hp_dout} : sp_dout; endfunction

    task automatic drive_in(input bit hp, input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] rnd);
        if (hp) begin
            hp_dv = v; hp_d1 = a[15:0]; hp_d2 = b[15:0]; hp_rnd = rnd;
        end else begin
            sp_dv = v; sp_d1 = a; sp_d2 = b; sp_rnd = rnd;
        end
    endtask

    task automatic set_out_ready(input bit hp, input logic v);
        if (hp) hp_or = v;
        else    sp_or = v;
    endtask

    // Exact product in integers, then rounding from quotient/remainder against half an ulp
    function automatic void model(input int ew, input int mw, input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] rnd, output logic [31:0] r, output logic [2:0] exc,
                                  output bit spc);
        longint emax, bias, e1, e2, f1, f2, p, q, rem, half, e, sl, res;
        bit s, nan1, nan2, inf1, inf2, z1, z2, up, inx, to_inf;
        int sh, wb;
        wb   = 1 + ew + mw;
        emax = (64'd1 << ew) - 1;
        bias = (64'd1 << (ew - 1)) - 1;
        s    = a[wb-1] ^ b[wb-1];
        sl   = s ? (64'd1 << (wb - 1)) : 64'd0;
        e1 = a >> mw; e1 = e1 & emax;
        e2 = b >> mw; e2 = e2 & emax;
        f1 = a; f1 = f1 & ((64'd1 << mw) - 1);
        f2 = b; f2 = f2 & ((64'd1 << mw) - 1);
        nan1 = (e1 == emax) && (f1 != 0); inf1 = (e1 == emax) && (f1 == 0); z1 = (e1 == 0);
        nan2 = (e2 == emax) && (f2 != 0); inf2 = (e2 == emax) && (f2 == 0); z2 = (e2 == 0);
        spc = nan1 || nan2 || inf1 || inf2 || z1 || z2;
        exc = 3'b000;
        res = 0;
        if (nan1 || nan2 || (inf1 && z2) || (z1 && inf2)) begin
            res = (emax << mw) | (64'd1 << (mw - 1));
            exc = 3'b011;
        end else if (inf1 || inf2) begin
            res = sl | (emax << mw);
        end else if (z1 || z2) begin
            res = sl;
        end else begin
            p  = ((64'd1 << mw) | f1) * ((64'd1 << mw) | f2);
            e  = e1 + e2 - bias;
            sh = mw;
            if (p >= (64'd1 << (2 * mw + 1))) begin
                e++;
                sh = mw + 1;
            end
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 0);
            case (rnd)
                2'b00:   up = (rem > half) || ((rem == half) && q[0]);
                2'b01:   up = 1'b0;
                2'b10:   up = !s && inx;
                default: up = s && inx;
            endcase
            if (up) q++;
            if (q == (64'd1 << (mw + 1))) begin
                q = 64'd1 << mw;
                e++;
            end
            if (e >= emax) begin
                to_inf = (rnd == 2'b00) || ((rnd == 2'b10) && !s) || ((rnd == 2'b11) && s);
                res = to_inf ? (sl | (emax << mw)) : (sl | ((emax - 1) << mw) | ((64'd1 << mw) - 1));
                exc = 3'b010;
            end else if (e <= 0) begin
                res = sl;
                exc = 3'b001;
            end else begin
                res = sl | (e << mw) | (q - (64'd1 << mw));
                exc = inx ? 3'b101 : 3'b000;
            end
        end
        r = 32'(res);
    endfunction

    task automatic run_op(input bit hp, input logic [31:0] a, input logic [31:0] b, input logic [1:0] rnd,
                          input int hold, input string tag, input bit fix, input logic [31:0] fr,
                          input logic [2:0] fe);
        int mw, cyc;
        logic [31:0] er, r0;
        logic [2:0] ee, x0;
        bit spc, bad;
        mw = hp ? 10 : 23;
        model(hp ? 5 : 8, mw, a, b, rnd, er, ee, spc);
        set_out_ready(hp, hold == 0);
        @(posedge CLK); #1;
        drive_in(hp, 1'b1, a, b, rnd);
        @(negedge CLK);
        chk({tag, ":ready"}, 32'(in_ready(hp)), 32'd1);
        @(posedge CLK); #1;
        drive_in(hp, 1'b0, 32'h0, 32'h0, 2'b00);
        cyc = 1;
        bad = 0;
        @(negedge CLK);
        while (!out_valid(hp) && cyc < 100) begin
            if (in_ready(hp) || out_exc(hp) != 3'b000 || !busy(hp)) bad = 1;
            @(posedge CLK); #1;
            cyc++;
            @(negedge CLK);
        end
        chk({tag, ":valid"}, 32'(out_valid(hp)), 32'd1);
        chk({tag, ":lat"}, cyc, spc ? 32'd2 : 32'(mw + 5));
        chk({tag, ":wait"}, 32'(bad), 32'd0);
        chk({tag, ":data"}, out_data(hp), er);
        chk({tag, ":exc"}, 32'(out_exc(hp)), 32'(ee));
        if (fix) begin
            chk({tag, ":data_ref"}, out_data(hp), fr);
            chk({tag, ":exc_ref"}, 32'(out_exc(hp)), 32'(fe));
        end
        if (hold > 0) begin
            r0 = out_data(hp);
            x0 = out_exc(hp);
            bad = 0;
            repeat (hold) begin
                @(posedge CLK); #1;
                @(negedge CLK);
                if (!out_valid(hp) || out_data(hp) != r0 || out_exc(hp) != x0 || in_ready(hp)) bad = 1;
            end
            chk({tag, ":stall"}, 32'(bad), 32'd0);
            set_out_ready(hp, 1'b1);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        chk({tag, ":drop"}, {28'h0, out_valid(hp), out_exc(hp)}, 32'd0);
    endtask

    function automatic logic [31:0] rand_op(input int ew, input int mw);
        logic [31:0] s, e, f;
        int emax, bias, k;
        emax = (1 << ew) - 1;
        bias = (1 << (ew - 1)) - 1;
        k = $urandom_range(0, 11);
        s = 32'($urandom_range(0, 1));
        f = $urandom & ((32'd1 << mw) - 1);
        if (k == 0)      e = 32'd0;
        else if (k == 1) e = 32'(emax);
        else if (k == 2) begin e = 32'(emax); f = 32'd0; end
        else if (k <= 5) e = 32'($urandom_range(1, emax - 1));
        else             e = 32'($urandom_range(bias - bias / 2, bias + bias / 2));
        if (k == 7) f = (32'd1 << mw) - 1;
        return (s << (ew + mw)) | (e << mw) | f;
    endfunction

    initial begin
        int stale;
        RST = 1'b1;
        drive_in(0, 1'b1, 32'h3FC00000, 32'h40000000, 2'b00);
        drive_in(1, 1'b1, 32'h3C00, 32'h3C00, 2'b00);
        sp_or = 1'b1;
        hp_or = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_sp_out", {sp_dout[27:0], sp_ov, sp_exc}, 32'd0);
        chk("rst_sp_ready_busy", {30'h0, sp_dr, sp_busy}, 32'd0);
        chk("rst_hp_out", {12'h0, hp_dout, hp_ov, hp_exc}, 32'd0);
        chk("rst_hp_ready_busy", {30'h0, hp_dr, hp_busy}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        drive_in(0, 1'b0, 32'h0, 32'h0, 2'b00);
        drive_in(1, 1'b0, 32'h0, 32'h0, 2'b00);
        @(negedge CLK);
        chk("post_rst_ready", {30'h0, sp_dr, hp_dr}, 32'd3);
        chk("post_rst_busy", {30'h0, sp_busy, hp_busy}, 32'd0);

        run_op(0, 32'h3FC00000, 32'h40000000, 2'b00, 0, "lat_1p5x2", 1, 32'h40400000, 3'b000);
        run_op(0, 32'h3F800001, 32'h3F800001, 2'b00, 0, "rne_tie_lo", 1, 32'h3F800002, 3'b101);
        run_op(0, 32'h3FFFFFFF, 32'h3FFFFFFF, 2'b01, 0, "rtz_sq", 1, 32'h407FFFFE, 3'b101);
        run_op(0, 32'h3FFFFFFF, 32'h3FFFFFFF, 2'b00, 0, "rne_sq", 0, 32'h0, 3'b000);
        run_op(0, 32'h3FFFFFFF, 32'h3FFFFFFF, 2'b10, 0, "rup_sq", 1, 32'h407FFFFF, 3'b101);
        run_op(0, 32'h7F7FFFFF, 32'h40000000, 2'b00, 0, "ovf_rne", 1, 32'h7F800000, 3'b010);
        run_op(0, 32'h7F7FFFFF, 32'h40000000, 2'b01, 0, "ovf_rtz", 1, 32'h7F7FFFFF, 3'b010);
        run_op(0, 32'h7F7FFFFF, 32'h40000000, 2'b11, 0, "ovf_rdn", 1, 32'h7F7FFFFF, 3'b010);
        run_op(0, 32'h7F7FFFFF, 32'h40000000, 2'b10, 0, "ovf_rup", 1, 32'h7F800000, 3'b010);
        run_op(0, 32'hC0000000, 32'h7F7FFFFF, 2'b11, 0, "ovf_neg_rdn", 1, 32'hFF800000, 3'b010);
        run_op(0, 32'h7F800000, 32'h00000000, 2'b00, 0, "inf_x_zero", 1, 32'h7FC00000, 3'b011);
        run_op(0, 32'hFF800000, 32'h40000000, 2'b00, 0, "ninf_x_two", 1, 32'hFF800000, 3'b000);
        run_op(0, 32'h00800000, 32'h3F000000, 2'b00, 0, "underflow", 1, 32'h00000000, 3'b001);
        run_op(0, 32'h3FC00000, 32'h40000000, 2'b00, 5, "backpressure", 1, 32'h40400000, 3'b000);
        run_op(1, 32'h3C00, 32'h3C00, 2'b00, 0, "hp_one", 1, 32'h3C00, 3'b000);
        run_op(1, 32'h7BFF, 32'h4000, 2'b00, 0, "hp_ovf", 1, 32'h7C00, 3'b010);

        // Abandon an operation mid-multiply; nothing may surface afterwards
        @(posedge CLK); #1;
        drive_in(0, 1'b1, 32'h3FC00000, 32'h40000000, 2'b00);
        @(posedge CLK); #1;
        drive_in(0, 1'b0, 32'h0, 32'h0, 2'b00);
        repeat (6) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("midmult_busy_before", 32'(sp_busy), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        chk("midmult_rst_valid", 32'(sp_ov), 32'd0);
        chk("midmult_rst_busy", 32'(sp_busy), 32'd0);
        chk("midmult_rst_ready", 32'(sp_dr), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("midmult_ready_after", 32'(sp_dr), 32'd1);
        stale = 0;
        repeat (40) begin
            @(negedge CLK);
            if (sp_ov || sp_busy) stale++;
        end
        chk("midmult_no_stale", stale, 32'd0);

        for (int i = 0; i < 150; i++) begin
            int hold;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_op(0, rand_op(8, 23), rand_op(8, 23), 2'($urandom_range(0, 3)), hold,
                   $sformatf("rsp%0d", i), 0, 32'h0, 3'b000);
        end
        for (int i = 0; i < 100; i++) begin
            int hold;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_op(1, rand_op(5, 10), rand_op(5, 10), 2'($urandom_range(0, 3)), hold,
                   $sformatf("rhp%0d", i), 0, 32'h0, 3'b000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
